// File: rtl/raster_stream_source.sv
// Raster pixel source: accepts an upstream pixel stream and tags each pixel with its
// column/row position, inserting horizontal and vertical blanking between rows/frames.
module raster_stream_source #(
    parameter int EXP_WIDTH    = 8,
    parameter int FRAC_WIDTH   = 23,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int H_BLANK      = 0,
    parameter int V_BLANK      = 0,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [FP_WIDTH_REG-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [FP_WIDTH_REG-1:0] data_o,
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o,
    output logic                    sof_o,
    output logic                    eof_o,
    output logic                    busy_o
);

    localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BLANK_W   = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

    localparam logic [15:0]        COL_LAST = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0]        ROW_LAST = 16'(IMAGE_HEIGHT - 1);
    localparam logic [BLANK_W-1:0] H_LAST   = BLANK_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [BLANK_W-1:0] V_LAST   = BLANK_W'((V_BLANK > 0) ? V_BLANK - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HBLANK,
        VBLANK
    } state_t;

    state_t             state, state_nxt;
    logic [BLANK_W-1:0] blank_cnt, blank_nxt;
    logic [15:0]        col_cnt, row_cnt;
    logic               accept, last_col, last_row;

    // ready_o comes from the state register only, so valid_i never loops back upstream.
    assign ready_o  = (state == ACTIVE);
    assign busy_o   = (state != IDLE);
    assign accept   = valid_i & ready_o;
    assign last_col = (col_cnt == COL_LAST);
    assign last_row = (row_cnt == ROW_LAST);

    // NOTE: sequential state is always assigned with <= so every register samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            blank_cnt <= '0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch can be inferred.
    always_comb begin
        state_nxt = state;
        blank_nxt = '0;
        case (state)
            IDLE: begin
                if (enable_i) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (accept && last_col) begin
                    if (last_row) begin
                        if (V_BLANK > 0)   state_nxt = VBLANK;
                        else if (enable_i) state_nxt = ACTIVE;
                        else               state_nxt = IDLE;
                    end else if (H_BLANK > 0) begin
                        state_nxt = HBLANK;
                    end
                end
            end
            HBLANK: begin
                if (blank_cnt == H_LAST) state_nxt = ACTIVE;
                else                     blank_nxt = blank_cnt + 1'b1;
            end
            VBLANK: begin
                // Last blanking cycle doubles as the enable sample for the next frame.
                if (blank_cnt == V_LAST) state_nxt = enable_i ? ACTIVE : IDLE;
                else                     blank_nxt = blank_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_cnt <= '0;
                row_cnt <= last_row ? 16'd0 : row_cnt + 16'd1;
            end else begin
                col_cnt <= col_cnt + 16'd1;
            end
        end
    end

    // Position/data registers hold between beats; only the strobes drop to 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            col_o   <= '0;
            row_o   <= '0;
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
            eof_o   <= 1'b0;
        end else begin
            valid_o <= accept;
            sof_o   <= accept && (col_cnt == 16'd0) && (row_cnt == 16'd0);
            eof_o   <= accept && last_col && last_row;
            if (accept) begin
                data_o <= data_i;
                col_o  <= col_cnt;
                row_o  <= row_cnt;
            end
        end
    end

endmodule

// File: tb/tb_raster_stream_source.sv
// Self-checking bench for raster_stream_source: three instances (4x3 with blanking,
// 4x3 without blanking, 1x1), table vectors, directed corner cases and a random model.
module tb_raster_stream_source;

    logic        clk;
    logic        rst;
    logic        en   [3];
    logic        vin  [3];
    logic [31:0] din  [3];
    logic        rdy  [3];
    logic [31:0] dout [3];
    logic [15:0] col  [3];
    logic [15:0] row  [3];
    logic        vo   [3];
    logic        sof  [3];
    logic        eof  [3];
    logic        busy [3];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    raster_stream_source #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .H_BLANK(2), .V_BLANK(3)) dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .data_i(din[0]), .valid_i(vin[0]),
        .ready_o(rdy[0]), .data_o(dout[0]), .col_o(col[0]), .row_o(row[0]),
        .valid_o(vo[0]), .sof_o(sof[0]), .eof_o(eof[0]), .busy_o(busy[0]));

    raster_stream_source #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .H_BLANK(0), .V_BLANK(0)) dut_z (
        .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .data_i(din[1]), .valid_i(vin[1]),
        .ready_o(rdy[1]), .data_o(dout[1]), .col_o(col[1]), .row_o(row[1]),
        .valid_o(vo[1]), .sof_o(sof[1]), .eof_o(eof[1]), .busy_o(busy[1]));

    raster_stream_source #(.IMAGE_WIDTH(1), .IMAGE_HEIGHT(1), .H_BLANK(0), .V_BLANK(0)) dut_one (
        .clk_i(clk), .rst_i(rst), .enable_i(en[2]), .data_i(din[2]), .valid_i(vin[2]),
        .ready_o(rdy[2]), .data_o(dout[2]), .col_o(col[2]), .row_o(row[2]),
        .valid_o(vo[2]), .sof_o(sof[2]), .eof_o(eof[2]), .busy_o(busy[2]));

    function automatic int pw(input int i); return (i == 2) ? 1 : 4; endfunction
    function automatic int ph(input int i); return (i == 2) ? 1 : 3; endfunction
    function automatic int phb(input int i); return (i == 0) ? 2 : 0; endfunction
    function automatic int pvb(input int i); return (i == 0) ? 3 : 0; endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {valid, sof, eof, ready, busy, col, row, data}
    function automatic logic [68:0] snap(input int i);
        return {vo[i], sof[i], eof[i], rdy[i], busy[i], col[i], row[i], dout[i]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; vin[i] = 1'b0; din[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle of inputs, then sample just after the edge that consumed them.
    task automatic step(input int i, input logic e, input logic v, input logic [31:0] d);
        @(negedge clk);
        en[i] = e; vin[i] = v; din[i] = d;
        @(posedge clk);
        #1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        en;
        logic        v;
        logic [31:0] d;
        logic [68:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic v, input logic [31:0] d,
                                input logic ev, input logic es, input logic ee,
                                input logic er, input logic eb, input logic [15:0] ec,
                                input logic [15:0] erw, input logic [31:0] ed);
        vec_t t;
        t.en = e; t.v = v; t.d = d;
        t.exp = {ev, es, ee, er, eb, ec, erw, ed};
        return t;
    endfunction

    // ---------------- reference model ----------------
    // Linear pixel index within the frame plus a count of remaining blank cycles.
    int          m_k   [3];
    int          m_gap [3];
    bit          m_run [3];
    logic        e_v   [3];
    logic        e_sof [3];
    logic        e_eof [3];
    logic [15:0] e_col [3];
    logic [15:0] e_row [3];
    logic [31:0] e_dat [3];

    task automatic model_init();
        for (int i = 0; i < 3; i++) begin
            m_k[i] = 0; m_gap[i] = 0; m_run[i] = 0;
            e_v[i] = 0; e_sof[i] = 0; e_eof[i] = 0;
            e_col[i] = 0; e_row[i] = 0; e_dat[i] = 0;
        end
    endtask

    function automatic logic [68:0] model_snap(input int i);
        logic r, b;
        r = m_run[i] && (m_gap[i] == 0);
        b = m_run[i] || (m_gap[i] > 0);
        return {e_v[i], e_sof[i], e_eof[i], r, b, e_col[i], e_row[i], e_dat[i]};
    endfunction

    task automatic model_step(input int i);
        int w, n;
        w = pw(i);
        n = pw(i) * ph(i);
        e_v[i] = 0; e_sof[i] = 0; e_eof[i] = 0;
        if (m_run[i] && m_gap[i] == 0 && vin[i]) begin
            e_v[i]   = 1;
            e_dat[i] = din[i];
            e_col[i] = 16'(m_k[i] % w);
            e_row[i] = 16'(m_k[i] / w);
            e_sof[i] = (m_k[i] == 0);
            e_eof[i] = (m_k[i] == n - 1);
            m_k[i]++;
            if (m_k[i] == n) begin
                m_k[i] = 0;
                if (pvb(i) > 0) begin
                    m_run[i] = 0;
                    m_gap[i] = pvb(i);
                end else begin
                    m_run[i] = en[i];
                end
            end else if (m_k[i] % w == 0) begin
                m_gap[i] = phb(i);
            end
        end else if (m_gap[i] > 0) begin
            m_gap[i]--;
            if (m_gap[i] == 0 && !m_run[i]) m_run[i] = en[i];
        end else if (!m_run[i]) begin
            m_run[i] = en[i];
        end
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs [10];
    int   bc   [64];
    int   bcol [64];
    int   brow [64];
    bit   bsof [64];
    bit   beof [64];
    bit   bh   [64];

    initial begin
        int n, eof_c, sof_c;
        logic v;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; vin[i] = 1'b0; din[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("reset_state%0d", i), snap(i), 69'd0);
        rst = 1'b0;

        // Frame start on dut_a: idle, enable, first beats, a stall, and HBLANK.
        vecs[0] = mk(0, 1, 32'h11, 0, 0, 0, 0, 0, 16'd0, 16'd0, 32'h0);
        vecs[1] = mk(1, 1, 32'h22, 0, 0, 0, 1, 1, 16'd0, 16'd0, 32'h0);
        vecs[2] = mk(0, 1, 32'hA0, 1, 1, 0, 1, 1, 16'd0, 16'd0, 32'hA0);
        vecs[3] = mk(0, 0, 32'hA1, 0, 0, 0, 1, 1, 16'd0, 16'd0, 32'hA0);
        vecs[4] = mk(0, 1, 32'hA2, 1, 0, 0, 1, 1, 16'd1, 16'd0, 32'hA2);
        vecs[5] = mk(0, 1, 32'hA3, 1, 0, 0, 1, 1, 16'd2, 16'd0, 32'hA3);
        vecs[6] = mk(0, 1, 32'hA4, 1, 0, 0, 0, 1, 16'd3, 16'd0, 32'hA4);
        vecs[7] = mk(0, 1, 32'hA5, 0, 0, 0, 0, 1, 16'd3, 16'd0, 32'hA4);
        vecs[8] = mk(0, 1, 32'hA6, 0, 0, 0, 1, 1, 16'd3, 16'd0, 32'hA4);
        vecs[9] = mk(0, 1, 32'hA7, 1, 0, 0, 1, 1, 16'd0, 16'd1, 32'hA7);
        for (int k = 0; k < 10; k++) begin
            step(0, vecs[k].en, vecs[k].v, vecs[k].d);
            check($sformatf("vec%0d", k), snap(0), vecs[k].exp);
        end

        // Basic frame: enable pulse, valid held high.
        do_reset();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            step(0, (c == 0), 1'b1, 32'(c));
            bh[c] = busy[0];
            if (vo[0] && n < 64) begin
                bc[n] = c; bcol[n] = col[0]; brow[n] = row[0]; bsof[n] = sof[0]; beof[n] = eof[0];
                n++;
            end
        end
        check("basic_beats", 32'(n), 32'd12);
        if (n >= 12) begin
            for (int b = 0; b < 12; b++)
                check($sformatf("basic_pos%0d", b), {bcol[b][15:0], brow[b][15:0], bsof[b], beof[b]},
                      {16'(b % 4), 16'(b / 4), (b == 0), (b == 11)});
            check("basic_hgap0", 32'(bc[4] - bc[3]), 32'd3);
            check("basic_hgap1", 32'(bc[8] - bc[7]), 32'd3);
            check("basic_no_gap", 32'(bc[1] - bc[0]), 32'd1);
            check("basic_vblank_busy", 1'(bh[bc[11] + 2]), 1'b1);
            check("basic_idle_after", 1'(bh[bc[11] + 3]), 1'b0);
        end

        // Back-to-back frames with enable held high.
        do_reset();
        eof_c = -1; sof_c = -1;
        for (int c = 0; c < 60; c++) begin
            step(0, 1'b1, 1'b1, 32'(c));
            if (eof[0] && vo[0] && eof_c < 0) eof_c = c;
            else if (sof[0] && vo[0] && eof_c >= 0 && sof_c < 0) sof_c = c;
        end
        check("b2b_eof_seen", 1'(eof_c >= 0), 1'b1);
        check("b2b_gap", 32'(sof_c - eof_c), 32'd4);

        // Zero blanking: 24 consecutive beats across two frames.
        do_reset();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            step(1, 1'b1, 1'b1, 32'(c));
            if (vo[1] && n < 64) begin
                bc[n] = c; bcol[n] = col[1]; brow[n] = row[1]; bsof[n] = sof[1]; beof[n] = eof[1];
                n++;
            end
        end
        check("zero_beats", 1'(n >= 24), 1'b1);
        if (n >= 24) begin
            check("zero_consecutive", 32'(bc[23] - bc[0]), 32'd23);
            check("zero_last", {bcol[11][15:0], brow[11][15:0], beof[11]}, {16'd3, 16'd2, 1'b1});
            check("zero_wrap", {bcol[12][15:0], brow[12][15:0], bsof[12]}, {16'd0, 16'd0, 1'b1});
        end

        // Upstream stalls on the unblanked instance: valid 1,0,0,1 pattern.
        do_reset();
        step(1, 1'b1, 1'b0, 32'h0);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            if (n >= 12) break;
            check($sformatf("stall_ready%0d", c), 1'(rdy[1]), 1'b1);
            v = (c % 4 == 0) || (c % 4 == 3);
            step(1, 1'b0, v, 32'h500 + 32'(c));
            check($sformatf("stall_valid%0d", c), 1'(vo[1]), v);
            if (vo[1]) begin
                check($sformatf("stall_beat%0d", n), {col[1], row[1], dout[1]},
                      {16'(n % 4), 16'(n / 4), 32'h500 + 32'(c)});
                n++;
            end
        end
        check("stall_beats", 32'(n), 32'd12);

        // Reset mid-frame after beat 6.
        do_reset();
        n = 0;
        for (int c = 0; c < 30; c++) begin
            if (n >= 6) break;
            step(0, 1'b1, 1'b1, 32'(c));
            if (vo[0]) n++;
        end
        rst = 1'b1;
        #1;
        check("midreset_zero", snap(0), 69'd0);
        @(negedge clk);
        en[0] = 1'b1; vin[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step(0, 1'b1, 1'b1, 32'hC0 + 32'(c));
            if (vo[0] && n == 0) begin
                check("midreset_first", {col[0], row[0], sof[0]}, {16'd0, 16'd0, 1'b1});
                n++;
            end
        end
        check("midreset_beat_seen", 32'(n), 32'd1);

        // Enable drops after beat 2; the frame still completes.
        do_reset();
        n = 0;
        for (int c = 0; c < 50; c++) begin
            step(0, (n < 2), 1'b1, 32'(c));
            if (vo[0]) n++;
        end
        check("drop_beats", 32'(n), 32'd12);
        check("drop_idle", {vo[0], busy[0]}, 2'b00);

        // Random traffic on all three instances against the model.
        do_reset();
        model_init();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                check($sformatf("rand%0d_c%0d", i, c), snap(i), model_snap(i));
            for (int i = 0; i < 3; i++) begin
                en[i]  = ($urandom_range(0, 3) == 0);
                vin[i] = ($urandom_range(0, 3) != 0);
                din[i] = $urandom;
            end
            for (int i = 0; i < 3; i++) model_step(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
